// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared state enumeration and widths for the sequential divider
package seq_divider_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int STEP_CNT_W = 4;
endpackage

// File: rtl/seq_divider.sv
// seq_divider: 16/8 unsigned restoring divider, one quotient bit per cycle
module seq_divider
  import seq_divider_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero
);
  state_e                state_q, state_d;
  logic [STEP_CNT_W-1:0] cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d, quotient_q, quotient_d, step_quo;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d, rem_q, rem_d, remainder_q, remainder_d, step_rem;
  logic [DIVISOR_W:0]    shifted;
  logic                  busy_q, busy_d, done_q, done_d, dbz_q, dbz_d, ge;
  // dvd_q doubles as the quotient shift register: dividend MSBs leave, quotient bits enter
  always_comb begin
    shifted  = {rem_q, dvd_q[DIVIDEND_W-1]};
    ge       = shifted >= {1'b0, dvs_q};
    step_rem = ge ? DIVISOR_W'(shifted - {1'b0, dvs_q}) : shifted[DIVISOR_W-1:0];
    step_quo = {dvd_q[DIVIDEND_W-2:0], ge};
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        cnt_d   = '1;
        dvd_d   = dividend;
        dvs_d   = divisor;
        rem_d   = '0;
        dbz_d   = 1'b0;
        busy_d  = divisor != '0;
      end
      RUN: if (dvs_q == '0) begin
        state_d     = DONE;
        done_d      = 1'b1;
        dbz_d       = 1'b1;
        quotient_d  = '1;
        remainder_d = dvd_q[DIVISOR_W-1:0];
      end else begin
        dvd_d  = step_quo;
        rem_d  = step_rem;
        cnt_d  = cnt_q - 1'b1;
        busy_d = cnt_q != '0;
        if (cnt_q == '0) begin
          state_d     = DONE;
          done_d      = 1'b1;
          quotient_d  = step_quo;
          remainder_d = step_rem;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
    end
  end
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks against a cycle-level arithmetic model
module tb_seq_divider;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [15:0] dividend = '0, quotient;
  logic [7:0]  divisor = '0, remainder;
  logic        busy, done, div_by_zero;
  int total = 0, bad = 0;
  bit run_cmp = 0;

  seq_divider dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // model: edge counter e; a capture at edge c makes busy visible after edges c..c+15,
  // done after edge c+16 (c+1 for divisor 0), and the next start is accepted two edges later
  int e = 0, done_edge = -1, free_edge = 0, b0 = -1, b1 = -2;
  logic [15:0] m_q = '0, p_q;
  logic [7:0]  m_r = '0, p_r;
  logic        m_z = 0, p_z, m_busy = 0, m_done = 0;
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      done_edge = -1; free_edge = e; b0 = -1; b1 = -2;
      m_q = '0; m_r = '0; m_z = 0; m_busy = 0; m_done = 0;
    end else begin
      e++;
      m_done = e == done_edge;
      if (m_done) begin m_q = p_q; m_r = p_r; m_z = p_z; end
      if (e >= free_edge && start) begin
        m_z = 0;
        if (divisor == 0) begin
          p_q = 16'hFFFF; p_r = dividend[7:0]; p_z = 1;
          done_edge = e + 1; b0 = -1; b1 = -2;
        end else begin
          p_q = dividend / divisor; p_r = 8'(dividend % divisor); p_z = 0;
          done_edge = e + 16; b0 = e; b1 = e + 15;
        end
        free_edge = done_edge + 2;
      end
      m_busy = e >= b0 && e <= b1;
    end
  end

  always @(negedge clk) if (run_cmp) begin
    chk("cyc_busy", busy, m_busy);
    chk("cyc_done", done, m_done);
    chk("cyc_quotient", quotient, m_q);
    chk("cyc_remainder", remainder, m_r);
    chk("cyc_dbz", div_by_zero, m_z);
  end

  // starts from an idle-safe point, scrambles operands after capture, returns on the done cycle
  task automatic do_div(input logic [15:0] a, input logic [7:0] b, output int lat, output bit busy_seen);
    @(negedge clk);
    dividend = a; divisor = b; start = 1;
    @(negedge clk);
    start = 0; dividend = ~a; divisor = ~b;
    lat = 1; busy_seen = busy;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      busy_seen |= busy;
    end
  endtask

  int lat, n, dn;
  bit bs;
  logic [15:0] ra;
  logic [7:0]  rb;
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst_n = 1;
    run_cmp = 1;
    do_div(16'd460, 8'd23, lat, bs);
    chk("460_23_lat", lat, 17); chk("460_23_q", quotient, 20); chk("460_23_r", remainder, 0);
    chk("460_23_z", div_by_zero, 0);
    do_div(16'd1000, 8'd7, lat, bs);
    chk("1000_7_q", quotient, 142); chk("1000_7_r", remainder, 6);
    do_div(16'hFFFF, 8'd1, lat, bs);
    chk("ffff_1_q", quotient, 16'hFFFF); chk("ffff_1_r", remainder, 0);
    do_div(16'd5, 8'd255, lat, bs);
    chk("5_255_q", quotient, 0); chk("5_255_r", remainder, 5);
    do_div(16'h1234, 8'd0, lat, bs);
    chk("dz_lat", lat, 2); chk("dz_q", quotient, 16'hFFFF); chk("dz_r", remainder, 8'h34);
    chk("dz_z", div_by_zero, 1); chk("dz_busy_seen", bs, 0);
    repeat (3) @(negedge clk);
    chk("dz_hold", div_by_zero, 1);
    // start held through the whole run with operands changed mid-run
    @(negedge clk);
    dividend = 100; divisor = 10; start = 1; n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 3) begin dividend = 50; divisor = 5; end
    end
    start = 0;
    chk("hold_lat", n, 17); chk("hold_q", quotient, 10); chk("hold_r", remainder, 0);
    dn = 0;
    repeat (20) begin @(negedge clk); dn += done; end
    chk("hold_extra_done", dn, 0);
    // asynchronous reset in the middle of a run
    @(negedge clk);
    dividend = 460; divisor = 23; start = 1;
    @(negedge clk);
    start = 0;
    repeat (7) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", busy, 0); chk("arst_q", quotient, 0); chk("arst_r", remainder, 0);
    chk("arst_done", done, 0); chk("arst_z", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    dn = 0;
    repeat (20) begin @(negedge clk); dn += done; end
    chk("arst_no_done", dn, 0);
    do_div(16'd460, 8'd23, lat, bs);
    chk("post_rst_lat", lat, 17); chk("post_rst_q", quotient, 20); chk("post_rst_r", remainder, 0);
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 8'($urandom_range(1, 255));
      do_div(ra, rb, lat, bs);
      chk("rand_lat", lat, 17);
      chk("rand_identity", longint'(quotient) * rb + remainder, ra);
      chk("rand_rem_lt", remainder < rb, 1);
    end
    @(negedge clk);
    run_cmp = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-004 The block SHALL have port dividend, input, 16 bits: unsigned numerator, captured on the accepted start.
REQ-005 The block SHALL have port divisor, input, 8 bits: unsigned denominator, captured on the accepted start.
REQ-006 The block SHALL have port quotient, output, 16 bits: unsigned result, registered.
REQ-007 The block SHALL have port remainder, output, 8 bits: unsigned remainder, registered.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-010 The block SHALL have port div_by_zero, output, 1 bit: high with done when the captured divisor was 0; held until the next accepted start.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 In IDLE, start=1 at a posedge SHALL capture both operands, clear div_by_zero and enter RUN; a 4-bit step counter SHALL be loaded with 15.
REQ-013 RUN SHALL perform one restoring step per cycle:
- shift the 9-bit partial remainder left, bringing in the next dividend MSB;
- compare the result against {1'b0, divisor};
- subtract if greater than or equal, and shift the quotient bit (1 or 0) into the quotient LSB.
REQ-014 RUN SHALL last exactly 16 cycles; on the posedge where the counter equals 0, the FSM SHALL enter DONE.
REQ-015 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-016 Total latency SHALL be 17 cycles: done SHALL be high in the 17th cycle after the start-capture edge.
REQ-017 The quotient and remainder outputs SHALL update only on entry to DONE.
REQ-018 The quotient and remainder outputs SHALL hold their values through IDLE until the next result.
REQ-019 start SHALL be ignored in RUN and DONE, and operand changes after capture SHALL have no effect.
REQ-020 A captured divisor of 0 SHALL skip RUN and enter DONE on the next posedge with:
- quotient=16'hFFFF;
- remainder=dividend[7:0];
- div_by_zero=1.
REQ-021 Arithmetic SHALL be unsigned.
REQ-022 The remainder SHALL always be less than the divisor and SHALL fit in 8 bits; the 9th bit of the partial remainder SHALL be internal only.
REQ-023 For a non-zero divisor, quotient*divisor+remainder SHALL equal dividend exactly.
REQ-024 busy SHALL be 1 only in RUN.

Reset
REQ-025 rst_n=0 SHALL immediately, without waiting for clk, force state to IDLE and set quotient=0, remainder=0, busy=0, done=0, div_by_zero=0 and the counter to 0.
REQ-026 Reset during RUN SHALL abort the division; no done pulse SHALL follow.
REQ-027 After rst_n deasserts, the first start SHALL be accepted normally.

Structure
REQ-028 A shared package SHALL hold:
- the state enumeration (IDLE, RUN, DONE);
- DIVIDEND_W=16 and DIVISOR_W=8;
- STEP_CNT_W=4.
REQ-029 The block SHALL be one module with no sub-module.
REQ-030 Seven-segment display of quotient and remainder SHALL be done at the board top with the existing hex decoder, outside this block.

Verification
REQ-031 Dividend 460, divisor 23, start pulsed one cycle -> busy for 16 cycles; done in the 17th cycle; quotient=20, remainder=0, div_by_zero=0.
REQ-032 Dividend 1000, divisor 7 -> quotient=142, remainder=6; dividend 16'hFFFF, divisor 1 -> quotient=16'hFFFF, remainder=0; dividend 5, divisor 255 -> quotient=0, remainder=5.
REQ-033 Dividend 16'h1234, divisor 0 -> done on the 2nd cycle after capture; quotient=16'hFFFF, remainder=8'h34, div_by_zero=1, busy never 1.
REQ-034 Start 100/10, then start held high for all of RUN with 50/5 driven from cycle 3 -> a single done; quotient=10, remainder=0; no second done unless start is sampled in IDLE.
REQ-035 rst_n pulsed low at cycle 8 of RUN, asynchronously between edges -> outputs 0 and state IDLE immediately; no done; a following 460/23 gives quotient=20 with 17-cycle latency.
REQ-036 Random self-check: 1000 operand pairs with non-zero divisor -> quotient*divisor+remainder==dividend and remainder<divisor every time.
